// File: rtl/educ8_timing_sequencer.sv
// EDUC-8 major-state / time-state sequencer.
// Generates the one-hot time pulses T0..T(N-1) and the FETCH/DEFER/EXECUTE
// major state, and gates the run state from the front-panel RUN/STOP/STEP
// pulses. A stop request is held pending until the next instruction
// boundary, so a cycle is never cut short.
// Optional feature macro: TIMING_BREAK_EN adds break_req/break_ack and the
// BREAK major state (11).
module educ8_timing_sequencer #(
  parameter int NUM_TSTATES = 8,
  parameter int TSW         = 4
) (
  input  logic                   clk,
  input  logic                   nclr,
  input  logic                   run_req,
  input  logic                   stop_req,
  input  logic                   step_req,
  input  logic                   halt,
  input  logic                   need_defer,
  input  logic                   need_exec,
`ifdef TIMING_BREAK_EN
  input  logic                   break_req,
  output logic                   break_ack,
`endif
  output logic [TSW-1:0]         tcount,
  output logic [NUM_TSTATES-1:0] tstate,
  output logic [1:0]             major,
  output logic                   running,
  output logic                   cycle_end,
  output logic                   instr_done
);

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    MAJ_FETCH = 2'b00,
    MAJ_DEFER = 2'b01,
    MAJ_EXEC  = 2'b10,
    MAJ_BREAK = 2'b11
  } major_t;

  localparam logic [TSW-1:0] LAST_T = TSW'(NUM_TSTATES - 1);

  mode_t          mode, mode_nxt;
  major_t         major_q, major_nxt;
  major_t         seq_major;
  logic [TSW-1:0] tcount_q, tcount_nxt;
  logic           stop_pend, stop_pend_nxt;
  logic           boundary;
  logic           stop_now;

  assign running   = (mode != MODE_IDLE);
  assign tcount    = tcount_q;
  assign major     = major_q;
  assign cycle_end = running && (tcount_q == LAST_T);

  // Major state the instruction flow would take next, ignoring breaks.
  always_comb begin
    seq_major = MAJ_FETCH;
    case (major_q)
      MAJ_FETCH: begin
        if (need_defer)     seq_major = MAJ_DEFER;
        else if (need_exec) seq_major = MAJ_EXEC;
        else                seq_major = MAJ_FETCH;
      end
      MAJ_DEFER: seq_major = need_exec ? MAJ_EXEC : MAJ_FETCH;
      default:   seq_major = MAJ_FETCH;
    endcase
  end

`ifdef TIMING_BREAK_EN
  // Instruction boundary excludes BREAK cycles; stop is checked at the end
  // of a BREAK cycle, or at instr_done when no break is being entered.
  always_comb begin
    instr_done = cycle_end && (seq_major == MAJ_FETCH) && (major_q != MAJ_BREAK);
    boundary   = (instr_done && !break_req) ||
                 (cycle_end && (major_q == MAJ_BREAK));
    break_ack  = running && (major_q == MAJ_BREAK);
  end
`else
  // Instruction boundary: last time state of a cycle heading back to FETCH.
  always_comb begin
    instr_done = cycle_end && (seq_major == MAJ_FETCH);
    boundary   = instr_done;
  end
`endif

  // A stop request arriving on the boundary clock counts immediately.
  assign stop_now = boundary &&
                    (stop_pend || stop_req || halt || (mode == MODE_STEP));

  // One-hot time pulse; all zero while idle.
  always_comb begin
    tstate = '0;
    for (int i = 0; i < NUM_TSTATES; i++) begin
      if (running && (tcount_q == TSW'(i))) tstate[i] = 1'b1;
    end
  end

  // Next-state logic for mode, time count, major state and pending stop.
  always_comb begin
    mode_nxt      = mode;
    major_nxt     = major_q;
    tcount_nxt    = tcount_q;
    stop_pend_nxt = stop_pend;
    case (mode)
      MODE_IDLE: begin
        tcount_nxt    = '0;
        major_nxt     = MAJ_FETCH;
        stop_pend_nxt = 1'b0;
        if (!stop_req) begin
          if (run_req)       mode_nxt = MODE_RUN;
          else if (step_req) mode_nxt = MODE_STEP;
        end
      end
      MODE_RUN, MODE_STEP: begin
        if (stop_now) begin
          mode_nxt      = MODE_IDLE;
          tcount_nxt    = '0;
          major_nxt     = MAJ_FETCH;
          stop_pend_nxt = 1'b0;
        end else begin
          stop_pend_nxt = stop_pend || stop_req;
          if (cycle_end) begin
            tcount_nxt = '0;
`ifdef TIMING_BREAK_EN
            if ((instr_done || (major_q == MAJ_BREAK)) && break_req)
              major_nxt = MAJ_BREAK;
            else
              major_nxt = seq_major;
`else
            major_nxt = seq_major;
`endif
          end else begin
            tcount_nxt = tcount_q + TSW'(1);
          end
        end
      end
      default: begin
        mode_nxt      = MODE_IDLE;
        tcount_nxt    = '0;
        major_nxt     = MAJ_FETCH;
        stop_pend_nxt = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      mode      <= MODE_IDLE;
      major_q   <= MAJ_FETCH;
      tcount_q  <= '0;
      stop_pend <= 1'b0;
    end else begin
      mode      <= mode_nxt;
      major_q   <= major_nxt;
      tcount_q  <= tcount_nxt;
      stop_pend <= stop_pend_nxt;
    end
  end

endmodule

// File: tb/tb_educ8_timing_sequencer.sv
// Directed testbench for educ8_timing_sequencer (default build, 8 T-states).
module tb_educ8_timing_sequencer;

  logic       clk;
  logic       nclr;
  logic       run_req, stop_req, step_req, halt, need_defer, need_exec;
  logic [3:0] tcount;
  logic [7:0] tstate;
  logic [1:0] major;
  logic       running, cycle_end, instr_done;

  int vectors;
  int miscompares;

  educ8_timing_sequencer #(.NUM_TSTATES(8), .TSW(4)) dut (
    .clk(clk), .nclr(nclr), .run_req(run_req), .stop_req(stop_req),
    .step_req(step_req), .halt(halt), .need_defer(need_defer),
    .need_exec(need_exec), .tcount(tcount), .tstate(tstate), .major(major),
    .running(running), .cycle_end(cycle_end), .instr_done(instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nclr = 1'b0;
    #1;
    vectors++;
    if (running !== 1'b0 || tcount !== 4'd0 || tstate !== 8'h00 || major !== 2'b00 ||
        cycle_end !== 1'b0 || instr_done !== 1'b0) begin
      $display("FAIL reset: run=%b tc=%0d ts=%h maj=%b ce=%b id=%b, want 0 0 00 00 0 0",
               running, tcount, tstate, major, cycle_end, instr_done);
      miscompares++;
    end
    @(posedge clk);
    #2 nclr = 1'b1;
    tick();
    vectors++;
    if (running !== 1'b0) begin
      $display("FAIL reset_idle: running=%b want 0", running);
      miscompares++;
    end
  endtask

  task automatic test_fetch_only();
    logic [7:0] exp_ts;
    run_req = 1'b1; tick(); run_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_ts = 8'd1 << i;
      vectors++;
      if (tstate !== exp_ts || tcount !== 4'(i) || major !== 2'b00 ||
          cycle_end !== (i == 7) || instr_done !== (i == 7) || running !== 1'b1) begin
        $display("FAIL fetch_walk t%0d: ts=%h tc=%0d maj=%b ce=%b id=%b run=%b, want ts=%h",
                 i, tstate, tcount, major, cycle_end, instr_done, running, exp_ts);
        miscompares++;
      end
      tick();
    end
    vectors++;
    if (tcount !== 4'd0 || tstate !== 8'h01 || major !== 2'b00 || running !== 1'b1) begin
      $display("FAIL fetch_wrap: tc=%0d ts=%h maj=%b run=%b, want 0 01 00 1",
               tcount, tstate, major, running);
      miscompares++;
    end
  endtask

  task automatic test_defer_exec();
    logic [1:0] exp_maj;
    need_defer = 1'b1; need_exec = 1'b1;
    for (int c = 0; c < 3; c++) begin
      exp_maj = 2'(c);
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (major !== exp_maj || tcount !== 4'(i) || instr_done !== (c == 2 && i == 7)) begin
          $display("FAIL defer_exec c%0d t%0d: maj=%b tc=%0d id=%b, want maj=%b id=%b",
                   c, i, major, tcount, instr_done, exp_maj, (c == 2 && i == 7));
          miscompares++;
        end
        tick();
      end
    end
    need_defer = 1'b0; need_exec = 1'b0;
    vectors++;
    if (major !== 2'b00 || tcount !== 4'd0) begin
      $display("FAIL defer_exec_back: maj=%b tc=%0d want 00 0", major, tcount);
      miscompares++;
    end
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    vectors++;
    if (running !== 1'b0 || tstate !== 8'h00 || tcount !== 4'd0) begin
      $display("FAIL defer_exec_stop: run=%b ts=%h tc=%0d want 0 00 0", running, tstate, tcount);
      miscompares++;
    end
  endtask

  task automatic test_step();
    need_exec = 1'b1;
    step_req = 1'b1; tick(); step_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (running !== 1'b1 || major !== ((i < 8) ? 2'b00 : 2'b10) || tcount !== 4'(i % 8)) begin
        $display("FAIL step clk%0d: run=%b maj=%b tc=%0d, want 1 %b %0d",
                 i, running, major, tcount, ((i < 8) ? 2'b00 : 2'b10), i % 8);
        miscompares++;
      end
      tick();
    end
    need_exec = 1'b0;
    vectors++;
    if (running !== 1'b0 || tstate !== 8'h00 || major !== 2'b00 || tcount !== 4'd0) begin
      $display("FAIL step_end: run=%b ts=%h maj=%b tc=%0d want 0 00 00 0",
               running, tstate, major, tcount);
      miscompares++;
    end
  endtask

  task automatic test_stop_pending();
    logic [1:0] exp_maj;
    logic [3:0] exp_tc;
    need_exec = 1'b1;
    run_req = 1'b1; tick(); run_req = 1'b0;
    tick(); tick();
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    for (int k = 0; k < 13; k++) begin
      exp_maj = (k < 5) ? 2'b00 : 2'b10;
      exp_tc  = (k < 5) ? 4'(3 + k) : 4'(k - 5);
      vectors++;
      if (running !== 1'b1 || major !== exp_maj || tcount !== exp_tc ||
          instr_done !== (k == 12)) begin
        $display("FAIL stop_pend k%0d: run=%b maj=%b tc=%0d id=%b, want 1 %b %0d %b",
                 k, running, major, tcount, instr_done, exp_maj, exp_tc, (k == 12));
        miscompares++;
      end
      if (k == 8) stop_req = 1'b1;
      tick();
      stop_req = 1'b0;
    end
    need_exec = 1'b0;
    vectors++;
    if (running !== 1'b0 || major !== 2'b00 || tcount !== 4'd0) begin
      $display("FAIL stop_pend_end: run=%b maj=%b tc=%0d want 0 00 0", running, major, tcount);
      miscompares++;
    end
  endtask

  task automatic test_stop_at_boundary();
    run_req = 1'b1; tick(); run_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    vectors++;
    if (instr_done !== 1'b1) begin
      $display("FAIL boundary_id: instr_done=%b want 1", instr_done);
      miscompares++;
    end
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    vectors++;
    if (running !== 1'b0 || tstate !== 8'h00) begin
      $display("FAIL boundary_stop: run=%b ts=%h want 0 00", running, tstate);
      miscompares++;
    end
  endtask

  task automatic test_halt();
    need_exec = 1'b1;
    run_req = 1'b1; tick(); run_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    halt = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    vectors++;
    if (running !== 1'b1 || major !== 2'b10 || tcount !== 4'd7 || instr_done !== 1'b1) begin
      $display("FAIL halt_last: run=%b maj=%b tc=%0d id=%b want 1 10 7 1",
               running, major, tcount, instr_done);
      miscompares++;
    end
    tick();
    vectors++;
    if (running !== 1'b0 || major !== 2'b00) begin
      $display("FAIL halt_idle: run=%b maj=%b want 0 00", running, major);
      miscompares++;
    end
    halt = 1'b0; need_exec = 1'b0;
    run_req = 1'b1; stop_req = 1'b1; tick(); run_req = 1'b0; stop_req = 1'b0;
    tick();
    vectors++;
    if (running !== 1'b0 || tcount !== 4'd0 || tstate !== 8'h00) begin
      $display("FAIL run_stop_same: run=%b tc=%0d ts=%h want 0 0 00", running, tcount, tstate);
      miscompares++;
    end
  endtask

  task automatic test_async_clear();
    need_defer = 1'b1; need_exec = 1'b1;
    run_req = 1'b1; tick(); run_req = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    vectors++;
    if (major !== 2'b01 || tcount !== 4'd5) begin
      $display("FAIL clr_setup: maj=%b tc=%0d want 01 5", major, tcount);
      miscompares++;
    end
    #2 nclr = 1'b0;
    #1;
    vectors++;
    if (running !== 1'b0 || tcount !== 4'd0 || tstate !== 8'h00 || major !== 2'b00 ||
        cycle_end !== 1'b0 || instr_done !== 1'b0) begin
      $display("FAIL async_clr: run=%b tc=%0d ts=%h maj=%b ce=%b id=%b want 0 0 00 00 0 0",
               running, tcount, tstate, major, cycle_end, instr_done);
      miscompares++;
    end
    need_defer = 1'b0; need_exec = 1'b0;
    @(posedge clk);
    #2 nclr = 1'b1;
    tick();
    run_req = 1'b1; tick(); run_req = 1'b0;
    vectors++;
    if (running !== 1'b1 || tcount !== 4'd0 || tstate !== 8'h01 || major !== 2'b00) begin
      $display("FAIL clr_restart: run=%b tc=%0d ts=%h maj=%b want 1 0 01 00",
               running, tcount, tstate, major);
      miscompares++;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    nclr = 1'b0; run_req = 1'b0; stop_req = 1'b0; step_req = 1'b0;
    halt = 1'b0; need_defer = 1'b0; need_exec = 1'b0;
    #1;
    test_reset();
    test_fetch_only();
    test_defer_exec();
    test_step();
    test_stop_pending();
    test_stop_at_boundary();
    test_halt();
    test_async_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
